// File: rtl/ga25_tile_fetch.sv
// Per-line tile fetch sequencer: VRAM attribute -> ROM bitplane row -> shifter load, one tile per 8 ce_pix.
// Optional underrun statistics are built only when GA25_FETCH_STATS_EN is defined.
module ga25_tile_fetch #(
  parameter int TILES_PER_LINE = 42,
  parameter int MAP_BASE       = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_pix,
  input  logic        line_start,
  input  logic [8:0]  vcount,
  input  logic [9:0]  hscroll,
  input  logic [9:0]  vscroll,
  output logic        vram_req,
  output logic [11:0] vram_addr,
  input  logic        vram_ack,
  input  logic [31:0] vram_data,
  output logic        rom_req,
  output logic [18:0] rom_addr,
  input  logic        rom_ack,
  input  logic [31:0] rom_data,
  output logic        load,
  output logic        reverse,
  output logic [31:0] row,
  output logic [3:0]  palette,
  output logic [1:0]  prio,
  output logic [2:0]  offset,
  output logic        active,
  output logic [7:0]  underrun_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ATTR, S_ROM, S_HOLD} state_t;

  localparam logic [11:0] BASE  = 12'(MAP_BASE);
  localparam logic [7:0]  NTILE = 8'(TILES_PER_LINE);

  state_t      r_state, w_state_nxt;
  logic [8:0]  r_y;
  logic [5:0]  r_col0;
  logic [2:0]  r_offset, r_slot;
  logic [7:0]  r_tile;
  logic        r_active, r_discard;
  logic [11:0] r_vram_addr;
  logic [18:0] r_rom_addr;
  logic [31:0] r_row_pend;
  logic [3:0]  r_pal_pend, r_pal_out;
  logic [1:0]  r_prio_pend, r_prio_out;
  logic        r_flipx_pend, r_rev_out;

  logic        w_slot_end, w_load, w_in_fetch, w_hit, w_miss, w_last, w_drop;
  logic        w_active_nxt, w_enter_attr, w_acc_attr, w_acc_rom;
  logic [7:0]  w_tile_inc, w_tile_nxt;
  logic [8:0]  w_y_nxt;
  logic [5:0]  w_col0_nxt, w_col;
  logic [11:0] w_vaddr_nxt;
  logic [2:0]  w_fy;
  logic        w_unused;

  assign w_unused     = &{1'b0, vram_data[31:24], vscroll[9], hscroll[9]};

  // line_start outranks a coincident slot end: no load, no tile advance
  assign w_slot_end   = r_active && ce_pix && (r_slot == 3'd7);
  assign w_load       = w_slot_end && !line_start;
  assign w_in_fetch   = (r_state == S_ATTR) || (r_state == S_ROM);
  assign w_hit        = w_load && (r_state == S_HOLD);
  assign w_miss       = w_load && w_in_fetch;
  assign w_tile_inc   = r_tile + 8'd1;
  assign w_last       = w_load && (w_tile_inc == NTILE);
  assign w_active_nxt = line_start || (r_active && !w_last);
  assign w_drop       = r_discard || w_miss || line_start;

  assign w_y_nxt      = line_start ? (vcount + vscroll[8:0]) : r_y;
  assign w_col0_nxt   = line_start ? hscroll[8:3] : r_col0;
  assign w_tile_nxt   = line_start ? 8'd0 : (w_load ? w_tile_inc : r_tile);
  assign w_col        = w_col0_nxt + w_tile_nxt[5:0];
  assign w_vaddr_nxt  = BASE + {w_y_nxt[8:3], w_col};
  assign w_fy         = vram_data[23] ? ~r_y[2:0] : r_y[2:0];

  assign w_enter_attr = (w_state_nxt == S_ATTR) && ((r_state != S_ATTR) || vram_ack);
  assign w_acc_attr   = (r_state == S_ATTR) && vram_ack && !w_drop;
  assign w_acc_rom    = (r_state == S_ROM) && rom_ack && !w_drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // A request caught by a miss or restart still runs to its ack; the data is then dropped
  always_comb begin
    w_state_nxt = r_state;
    vram_req    = 1'b0;
    rom_req     = 1'b0;
    case (r_state)
      S_IDLE: if (line_start) w_state_nxt = S_ATTR;
      S_ATTR: begin
        vram_req = 1'b1;
        if (vram_ack) w_state_nxt = w_drop ? (w_active_nxt ? S_ATTR : S_IDLE) : S_ROM;
      end
      S_ROM: begin
        rom_req = 1'b1;
        if (rom_ack) w_state_nxt = w_drop ? (w_active_nxt ? S_ATTR : S_IDLE) : S_HOLD;
      end
      S_HOLD: begin
        if (line_start)  w_state_nxt = S_ATTR;
        else if (w_load) w_state_nxt = w_active_nxt ? S_ATTR : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_y          <= '0;
      r_col0       <= '0;
      r_offset     <= '0;
      r_slot       <= '0;
      r_tile       <= '0;
      r_active     <= 1'b0;
      r_discard    <= 1'b0;
      r_vram_addr  <= '0;
      r_rom_addr   <= '0;
      r_row_pend   <= '0;
      r_pal_pend   <= '0;
      r_prio_pend  <= '0;
      r_flipx_pend <= 1'b0;
      r_pal_out    <= '0;
      r_prio_out   <= '0;
      r_rev_out    <= 1'b0;
    end else begin
      r_y      <= w_y_nxt;
      r_col0   <= w_col0_nxt;
      r_tile   <= w_tile_nxt;
      r_active <= w_active_nxt;
      if (line_start) r_offset <= hscroll[2:0];
      if (line_start)              r_slot <= '0;
      else if (r_active && ce_pix) r_slot <= r_slot + 3'd1;
      r_discard <= w_in_fetch && w_drop &&
                   !(((r_state == S_ATTR) && vram_ack) || ((r_state == S_ROM) && rom_ack));
      if (w_enter_attr) r_vram_addr <= w_vaddr_nxt;
      if (w_acc_attr) begin
        r_rom_addr   <= {vram_data[15:0], w_fy};
        r_pal_pend   <= vram_data[19:16];
        r_prio_pend  <= vram_data[21:20];
        r_flipx_pend <= vram_data[22];
      end
      if (w_acc_rom) r_row_pend <= rom_data;
      if (w_hit) begin
        r_pal_out  <= r_pal_pend;
        r_prio_out <= r_prio_pend;
        r_rev_out  <= r_flipx_pend;
      end
    end
  end

  // A missed tile is shown transparent with the previously presented attributes
  assign load      = w_load;
  assign row       = w_hit ? r_row_pend : 32'd0;
  assign palette   = w_hit ? r_pal_pend : r_pal_out;
  assign prio      = w_hit ? r_prio_pend : r_prio_out;
  assign reverse   = w_hit ? r_flipx_pend : r_rev_out;
  assign offset    = r_offset;
  assign active    = r_active;
  assign vram_addr = r_vram_addr;
  assign rom_addr  = r_rom_addr;

`ifdef GA25_FETCH_STATS_EN
  logic [7:0] r_underrun;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            r_underrun <= '0;
    else if (w_miss && (r_underrun != 8'hFF)) r_underrun <= r_underrun + 8'd1;
  end
  assign underrun_cnt = r_underrun;
`else
  assign underrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ga25_tile_fetch.sv
// Bench for ga25_tile_fetch: line-level reference model feeds scoreboards, a forked monitor checks.
module tb_ga25_tile_fetch;
  localparam int NT    = 42;
  localparam int BASE  = 0;
  localparam int CEDIV = 4;

  logic        clk = 0, reset_n = 1, ce_pix = 0, line_start = 0;
  logic [8:0]  vcount = 0;
  logic [9:0]  hscroll = 0, vscroll = 0;
  logic        vram_req, vram_ack, rom_req, rom_ack;
  logic [11:0] vram_addr;
  logic [18:0] rom_addr;
  logic [31:0] vram_data, rom_data, row;
  logic        load, reverse, active;
  logic [3:0]  palette;
  logic [1:0]  prio;
  logic [2:0]  offset;
  logic [7:0]  underrun_cnt;

  ga25_tile_fetch #(.TILES_PER_LINE(NT), .MAP_BASE(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .line_start(line_start),
    .vcount(vcount), .hscroll(hscroll), .vscroll(vscroll),
    .vram_req(vram_req), .vram_addr(vram_addr), .vram_ack(vram_ack), .vram_data(vram_data),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .load(load), .reverse(reverse), .row(row), .palette(palette), .prio(prio),
    .offset(offset), .active(active), .underrun_cnt(underrun_cnt));

  always #5 clk = ~clk;

  // Memory responders: programmable wait, one-shot stall by ROM transaction index, manual hold
  logic [31:0] vmem [4096];
  logic [31:0] rom_salt = 32'h1;
  int vlat = 0, rlat = 0, stall_idx = -1, stall_lat = 0;
  int vcnt = 0, rcnt = 0, racks = 0;
  logic rom_hold = 0;

  function automatic logic [31:0] romf(input logic [18:0] a);
    return ({13'd0, a} * 32'h9E37_79B1) ^ rom_salt;
  endfunction

  assign vram_ack  = vram_req && (vcnt >= vlat);
  assign vram_data = vmem[vram_addr];
  assign rom_ack   = rom_req && !rom_hold && (rcnt >= ((racks == stall_idx) ? stall_lat : rlat));
  assign rom_data  = romf(rom_addr);

  always @(posedge clk) begin
    vcnt <= (vram_req && !vram_ack) ? vcnt + 1 : 0;
    rcnt <= (rom_req && !rom_ack) ? rcnt + 1 : 0;
    if (line_start)            racks <= 0;
    else if (rom_req && rom_ack) racks <= racks + 1;
  end

  typedef struct packed {
    logic [31:0] row;
    logic [3:0]  pal;
    logic [1:0]  prio;
    logic        rev;
    logic [2:0]  off;
  } ld_t;

  ld_t         q_ld[$];
  logic [11:0] q_va[$];
  logic [18:0] q_ra[$];
  ld_t         lp;
  int          rom_skip = 0;
  int          n_tests = 0, n_fail = 0;
  int          exp_urun = 0;
  int          ce_ph = 0, ce_ls = 0;
  logic [3:0]  m_pal = 0;
  logic [1:0]  m_prio = 0;
  logic        m_rev = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each tile's fetch addresses and shifter drive, derived from scroll arithmetic
  task automatic push_line(input int vc, input int hs, input int vs, input int miss_tile);
    int y, col0, off, col, va, code, fy, ra;
    logic [31:0] a;
    ld_t e;
    y = (vc + vs) % 512; col0 = hs / 8; off = hs % 8;
    for (int t = 0; t < NT; t++) begin
      col  = (col0 + t) % 64;
      va   = (BASE + (y / 8) * 64 + col) % 4096;
      a    = vmem[va];
      code = int'(a[15:0]);
      fy   = a[23] ? 7 - (y % 8) : y % 8;
      ra   = code * 8 + fy;
      q_va.push_back(12'(va));
      q_ra.push_back(19'(ra));
      if (t == miss_tile) begin
        e = '{row: 32'd0, pal: m_pal, prio: m_prio, rev: m_rev, off: 3'(off)};
`ifdef GA25_FETCH_STATS_EN
        exp_urun++;
`endif
      end else begin
        e = '{row: romf(19'(ra)), pal: a[19:16], prio: a[21:20], rev: a[22], off: 3'(off)};
        m_pal = a[19:16]; m_prio = a[21:20]; m_rev = a[22];
      end
      q_ld.push_back(e);
    end
  endtask

  task automatic monitor();
    int cs = 0;
    ld_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (line_start) cs = 0;
        else if (ce_pix) cs++;
        if (vram_req && vram_ack) begin
          if (q_va.size() == 0) chk("vram_unexpected", 1, 0);
          else chk("vram_addr", 64'(vram_addr), 64'(q_va.pop_front()));
        end
        if (rom_req && rom_ack) begin
          if (rom_skip > 0) rom_skip--;
          else if (q_ra.size() == 0) chk("rom_unexpected", 1, 0);
          else chk("rom_addr", 64'(rom_addr), 64'(q_ra.pop_front()));
        end
        if (load) begin
          if (q_ld.size() == 0) chk("load_unexpected", 1, 0);
          else begin
            e = q_ld.pop_front();
            chk("row", 64'(row), 64'(e.row));
            chk("palette", 64'(palette), 64'(e.pal));
            chk("prio", 64'(prio), 64'(e.prio));
            chk("reverse", 64'(reverse), 64'(e.rev));
            chk("offset", 64'(offset), 64'(e.off));
            chk("load_spacing", 64'(cs), 64'd8);
            lp = e;
          end
          cs = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ce_ph      = (ce_ph + 1) % CEDIV;
    ce_pix     = (ce_ph == 0);
    line_start = 0;
    if (ce_pix) ce_ls++;
  endtask

  task automatic start_line(input int vc, input int hs, input int vs, input int miss_tile);
    while (ce_pix) tick();
    push_line(vc, hs, vs, miss_tile);
    vcount = 9'(vc); hscroll = 10'(hs); vscroll = 10'(vs);
    line_start = 1; ce_ls = 0;
    tick();
  endtask

  task automatic finish_line(input string nm);
    for (int i = 0; i < NT * 8 * CEDIV + 400 && active; i++) tick();
    chk({nm, "_done"}, 64'(active), 0);
    repeat (6) tick();
    chk({nm, "_loads_left"}, 64'(q_ld.size()), 0);
    chk({nm, "_attr_left"}, 64'(q_va.size()), 0);
    chk({nm, "_underrun"}, 64'(underrun_cnt), 64'(exp_urun));
  endtask

  initial begin
    int hold_err, hs2, vs2;
    for (int i = 0; i < 4096; i++) vmem[i] = $urandom;
    rom_salt = $urandom;
    fork monitor(); join_none

    #2 reset_n = 0;
    repeat (3) tick();
    chk("rst_active", 64'(active), 0);
    chk("rst_reqs", 64'({vram_req, rom_req, load}), 0);
    chk("rst_drive", 64'({row, palette, prio, reverse, offset}), 0);
    chk("rst_underrun", 64'(underrun_cnt), 0);
    reset_n = 1;
    repeat (4) tick();

    start_line(5, 0, 0, -1);
    finish_line("basic");

    start_line(3, 10'h3FD, 10'h1FE, -1);
    finish_line("scroll_wrap");

    vmem[64] = 32'h00C3_1234;
    start_line(10, 0, 0, -1);
    finish_line("flip");

    for (int k = 0; k < 2; k++) begin
      vlat = $urandom_range(0, 4); rlat = $urandom_range(0, 4);
      start_line($urandom_range(0, 511), $urandom_range(0, 1023), $urandom_range(0, 1023), -1);
      finish_line("random");
    end
    vlat = 0; rlat = 0;

    stall_idx = 4; stall_lat = 9 * CEDIV;
    start_line($urandom_range(0, 511), $urandom_range(0, 1023), $urandom_range(0, 1023), 4);
    finish_line("stall");
    stall_idx = -1;

    // Restart on tile 10's slot end while its ROM request is held pending
    start_line(100, 16, 4, -1);
    for (int i = 0; i < 4000 && ce_ls < 80; i++) tick();
    rom_hold = 1;
    for (int i = 0; i < 4000 && ce_ls < 88; i++) tick();
    chk("restart_rom_pending", 64'(rom_req), 1);
    chk("restart_loads_before", 64'(q_ld.size()), 64'(NT - 10));
    q_ld.delete(); q_va.delete(); q_ra.delete();
    m_pal = lp.pal; m_prio = lp.prio; m_rev = lp.rev;
    rom_skip = 1;
    hs2 = $urandom_range(0, 1023); vs2 = $urandom_range(0, 1023);
    push_line(200, hs2, vs2, -1);
    vcount = 9'd200; hscroll = 10'(hs2); vscroll = 10'(vs2);
    line_start = 1; ce_ls = 0;
    #1 chk("restart_no_load", 64'(load), 0);
    tick();
    hold_err = 0;
    for (int i = 0; i < 3; i++) begin
      if (!rom_req || vram_req) hold_err++;
      tick();
    end
    chk("restart_req_held", 64'(hold_err), 0);
    chk("restart_offset", 64'(offset), 64'(hs2 % 8));
    rom_hold = 0;
    for (int i = 0; i < 20 && !vram_req; i++) tick();
    chk("restart_attr", 64'(vram_req), 1);
    finish_line("restart");

    // Asynchronous reset in the middle of a line
    start_line(7, $urandom_range(0, 1023), $urandom_range(0, 1023), -1);
    repeat (100) tick();
    #2 reset_n = 0;
    #1;
    chk("arst_active", 64'(active), 0);
    chk("arst_reqs", 64'({vram_req, rom_req, load}), 0);
    chk("arst_drive", 64'({row, palette, prio, reverse, offset}), 0);
    chk("arst_addr", 64'({vram_addr, rom_addr}), 0);
    chk("arst_underrun", 64'(underrun_cnt), 0);
    q_ld.delete(); q_va.delete(); q_ra.delete();
    m_pal = 0; m_prio = 0; m_rev = 0; exp_urun = 0;
    repeat (3) tick();
    reset_n = 1;
    hold_err = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (active || vram_req || rom_req || load) hold_err++;
    end
    chk("post_reset_idle", 64'(hold_err), 0);

    start_line(33, $urandom_range(0, 1023), $urandom_range(0, 1023), -1);
    finish_line("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
